cla_nibble_seq: RTL

- Sequencer that performs NIBBLES×4-bit additions by time-multiplexing one external 4-bit carry-lookahead adder slice.
- Processes one nibble per cycle, LSB first, and ripples the carry through a register between cycles.
- Sits between a valid/ready operand source and a valid/ready result sink.
- The adder slice is combinational and instantiated beside this block: a, b, cin in; sum, cout out.

---
 rtl/cla_nibble_seq.sv | 118 +++++++++++
 1 files changed

// File: rtl/cla_nibble_seq.sv
// Nibble-serial adder sequencer driving one external 4-bit CLA slice.
// Optional subtract mode: define CLA_SEQ_SUB_EN to add the op_sub port.
module cla_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                 op_sub,
`endif
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 out_cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg, b_reg;
  logic [W-1:0]  b_in;
  logic          cin_in;
  logic          accept;

  // Subtraction is a + ~b + 1, folded into the operand latch.
`ifdef CLA_SEQ_SUB_EN
  assign b_in   = op_sub ? ~op_b : op_b;
  assign cin_in = op_sub ? 1'b1 : op_cin;
`else
  assign b_in   = op_b;
  assign cin_in = op_cin;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[{idx, 2'b00} +: 4];
        add_b   = b_reg[{idx, 2'b00} +: 4];
        add_cin = carry;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      result   <= '0;
      out_cout <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_reg <= op_a;
        b_reg <= b_in;
        carry <= cin_in;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= add_sum;
      carry <= add_cout;
      if (idx == LAST) begin
        out_cout <= add_cout;
        idx      <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
